// File: rtl/cofactor_pkg.sv
// cofactor_pkg: literal encoding, tableau row type and streamer state shared by the row streamer.
package cofactor_pkg;

    localparam int NUM_QUBIT = 3;

    localparam logic [1:0] LIT_I = 2'd0;
    localparam logic [1:0] LIT_X = 2'd1;
    localparam logic [1:0] LIT_Z = 2'd2;
    localparam logic [1:0] LIT_Y = 2'd3;

    // literals[i] is the Pauli literal on qubit i
    typedef struct packed {
        logic [NUM_QUBIT-1:0][1:0]  literals;
        logic [2**NUM_QUBIT-1:0]    phase;
    } row_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        PULSE_P,
        WAIT_FLAG,
        WAIT_CANON,
        RE_P,
        COLLECT,
        DONE
    } strm_state_e;

endpackage

// File: rtl/cofactor_row_streamer_if.sv
// cofactor_row_streamer_if: row stream and result bus between the host streamer and the cofactor control unit.
interface cofactor_row_streamer_if #(
    parameter int num_qubit = 3
);

    logic                       valid_in;
    logic [2*num_qubit-1:0]     literals_in;
    logic [2**num_qubit-1:0]    phase_in;
    logic                       valid_P;
    logic                       valid_flag_anticommute;
    logic                       flag_anticommute;
    logic                       valid_out_canonical;
    logic                       valid_out;
    logic [2*num_qubit-1:0]     literals_out;
    logic [2**num_qubit-1:0]    phase_out;

    modport master (
        output valid_in, literals_in, phase_in, valid_P,
        input  valid_flag_anticommute, flag_anticommute, valid_out_canonical,
        input  valid_out, literals_out, phase_out
    );

    modport slave (
        input  valid_in, literals_in, phase_in, valid_P,
        output valid_flag_anticommute, flag_anticommute, valid_out_canonical,
        output valid_out, literals_out, phase_out
    );

endinterface

// File: rtl/stabilizer_row_buffer.sv
// stabilizer_row_buffer: tableau register file, one write port, host and stream read ports.
module stabilizer_row_buffer #(
    parameter int num_qubit = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [$clog2(num_qubit)-1:0]    waddr,
    input  logic [2*num_qubit-1:0]          wlit,
    input  logic [2**num_qubit-1:0]         wph,
    input  logic [$clog2(num_qubit)-1:0]    hidx,
    output logic [2*num_qubit-1:0]          hlit,
    output logic [2**num_qubit-1:0]         hph,
    input  logic [$clog2(num_qubit)-1:0]    sidx,
    output logic [2*num_qubit-1:0]          slit,
    output logic [2**num_qubit-1:0]         sph
);

    localparam int IW = $clog2(num_qubit);
    localparam logic [IW:0] NQ = (IW+1)'(num_qubit);

    logic [2*num_qubit-1:0]  lit_q [num_qubit];
    logic [2*num_qubit-1:0]  lit_d [num_qubit];
    logic [2**num_qubit-1:0] ph_q  [num_qubit];
    logic [2**num_qubit-1:0] ph_d  [num_qubit];
    logic hit, fwd;

    always_comb begin
        lit_d = lit_q;
        ph_d  = ph_q;
        if (we && {1'b0, waddr} < NQ) begin
            lit_d[waddr] = wlit;
            ph_d[waddr]  = wph;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lit_q <= '{default: '0};
            ph_q  <= '{default: '0};
        end else begin
            lit_q <= lit_d;
            ph_q  <= ph_d;
        end
    end

    assign hit  = {1'b0, hidx} < NQ;
    assign hlit = hit ? lit_q[hidx] : '0;
    assign hph  = hit ? ph_q[hidx] : '0;

    // a load landing in the same cycle as start must already appear in the stream
    assign fwd  = we && waddr == sidx;
    assign slit = fwd ? wlit : lit_q[sidx];
    assign sph  = fwd ? wph : ph_q[sidx];

endmodule

// File: rtl/cofactor_row_streamer.sv
// cofactor_row_streamer: streams the tableau into the cofactor unit, runs the optional
// randomized round and writes the returned rows back in place.
module cofactor_row_streamer
    import cofactor_pkg::*;
#(
    parameter int num_qubit = NUM_QUBIT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_valid,
    input  logic [$clog2(num_qubit)-1:0]    load_idx,
    input  logic [2*num_qubit-1:0]          load_literals,
    input  logic [2**num_qubit-1:0]         load_phase,
    input  logic                            start,
    output logic [2*num_qubit-1:0]          rd_literals,
    output logic [2**num_qubit-1:0]         rd_phase,
    cofactor_row_streamer_if.master         cu,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int IW = $clog2(num_qubit);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] NQ   = CW'(num_qubit);
    localparam logic [CW-1:0] LAST = CW'(num_qubit - 1);

    strm_state_e state_q, state_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d, canon_cnt_q, canon_cnt_d;
    logic rand_seen_q, rand_seen_d, err_q, err_d;
    logic valid_in_q, valid_in_d, valid_p_q, valid_p_d;
    logic [2*num_qubit-1:0]  literals_in_q, literals_in_d, wlit, slit;
    logic [2**num_qubit-1:0] phase_in_q, phase_in_d, wph, sph;
    logic load_we, cap_we, we;
    logic [IW-1:0] waddr;

    assign load_we = state_q == IDLE && load_valid;
    assign cap_we  = (state_q == WAIT_FLAG || state_q == COLLECT) && cu.valid_out && row_cnt_q < NQ;
    assign we      = load_we || cap_we;
    assign waddr   = load_we ? load_idx : row_cnt_q[IW-1:0];
    assign wlit    = load_we ? load_literals : cu.literals_out;
    assign wph     = load_we ? load_phase : cu.phase_out;

    stabilizer_row_buffer #(.num_qubit(num_qubit)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wlit  (wlit),
        .wph   (wph),
        .hidx  (load_idx),
        .hlit  (rd_literals),
        .hph   (rd_phase),
        .sidx  (row_cnt_d[IW-1:0]),
        .slit  (slit),
        .sph   (sph)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            canon_cnt_q   <= '0;
            rand_seen_q   <= 1'b0;
            err_q         <= 1'b0;
            valid_in_q    <= 1'b0;
            valid_p_q     <= 1'b0;
            literals_in_q <= '0;
            phase_in_q    <= '0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            canon_cnt_q   <= canon_cnt_d;
            rand_seen_q   <= rand_seen_d;
            err_q         <= err_d;
            valid_in_q    <= valid_in_d;
            valid_p_q     <= valid_p_d;
            literals_in_q <= literals_in_d;
            phase_in_q    <= phase_in_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = cap_we ? row_cnt_q + 1'b1 : row_cnt_q;
        canon_cnt_d = canon_cnt_q;
        rand_seen_d = rand_seen_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = SEND;
                row_cnt_d   = '0;
                rand_seen_d = 1'b0;
                err_d       = 1'b0;
            end
            SEND: begin
                row_cnt_d = row_cnt_q + 1'b1;
                state_d   = row_cnt_q == LAST ? PULSE_P : SEND;
            end
            PULSE_P, RE_P: begin
                row_cnt_d = '0;
                state_d   = WAIT_FLAG;
            end
            WAIT_FLAG: if (cu.valid_flag_anticommute) begin
                if (!cu.flag_anticommute) begin
                    state_d = row_cnt_d == NQ ? DONE : COLLECT;
                end else if (!rand_seen_q) begin
                    rand_seen_d = 1'b1;
                    canon_cnt_d = '0;
                    state_d     = WAIT_CANON;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_CANON: if (cu.valid_out_canonical) begin
                canon_cnt_d = canon_cnt_q + 1'b1;
                state_d     = canon_cnt_d == NQ ? RE_P : WAIT_CANON;
            end
            COLLECT: state_d = row_cnt_d == NQ ? DONE : COLLECT;
            DONE:    state_d = IDLE;
        endcase
    end

    // unit-facing outputs are registered off the next state so they line up with it
    always_comb begin
        busy          = state_q != IDLE;
        done          = state_q == DONE;
        valid_in_d    = state_d == SEND;
        literals_in_d = valid_in_d ? slit : '0;
        phase_in_d    = valid_in_d ? sph : '0;
        valid_p_d     = state_d == PULSE_P || state_d == RE_P;
    end

    assign cu.valid_in    = valid_in_q;
    assign cu.literals_in = literals_in_q;
    assign cu.phase_in    = phase_in_q;
    assign cu.valid_P     = valid_p_q;
    assign err            = err_q;

endmodule

// File: tb/tb_cofactor_row_streamer.sv
// tb_cofactor_row_streamer: scoreboard bench for the cofactor row streamer.
module tb_cofactor_row_streamer;
    import cofactor_pkg::*;

    typedef struct {
        row_t r;
        int   c;
    } sb_t;

    logic clk = 0, rst = 0, load_valid = 0, start = 0;
    logic [1:0] load_idx = 0;
    logic [5:0] load_literals = 0, rd_literals;
    logic [7:0] load_phase = 0, rd_phase;
    logic busy, done, err;
    int total = 0, bad = 0, cyc = 0, n_p = 0, n_done = 0;
    int last_c = 0, t0 = 0, at = 0, base_p = 0, base_d = 0;
    row_t model [3];
    sb_t sb [$];
    sb_t e_mon;

    cofactor_row_streamer_if #(.num_qubit(3)) cu();

    cofactor_row_streamer #(.num_qubit(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_idx      (load_idx),
        .load_literals (load_literals),
        .load_phase    (load_phase),
        .start         (start),
        .rd_literals   (rd_literals),
        .rd_phase      (rd_phase),
        .cu            (cu),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic row_t mk(input logic [1:0] a, b, c, input logic [7:0] ph);
        row_t r;
        r.literals = {c, b, a};
        r.phase    = ph;
        return r;
    endfunction

    always @(negedge clk) begin
        if (cu.valid_P) n_p++;
        if (done) n_done++;
        if (cu.valid_in) begin
            if (sb.size() == 0) chk("stream_extra", 1, 0);
            else begin
                e_mon = sb.pop_front();
                chk("stream_lit", cu.literals_in, e_mon.r.literals);
                chk("stream_ph", cu.phase_in, e_mon.r.phase);
                chk("stream_cyc", cyc, e_mon.c);
            end
        end
    end

    task automatic load(input int i, input row_t r);
        @(negedge clk);
        load_valid = 1; load_idx = 2'(i); load_literals = r.literals; load_phase = r.phase;
        model[i] = r;
        @(negedge clk);
        load_valid = 0;
    endtask

    task automatic kick(input logic ld, input int i, input row_t r);
        @(negedge clk);
        start = 1;
        if (ld) begin
            load_valid = 1; load_idx = 2'(i); load_literals = r.literals; load_phase = r.phase;
            model[i] = r;
        end
        t0 = cyc;
        for (int k = 0; k < 3; k++) sb.push_back('{model[k], cyc + 1 + k});
        @(negedge clk);
        start = 0; load_valid = 0;
    endtask

    task automatic cu_drive(input logic vf, f, vc, vo, input row_t r);
        @(negedge clk);
        cu.valid_flag_anticommute = vf; cu.flag_anticommute = f;
        cu.valid_out_canonical = vc; cu.valid_out = vo;
        cu.literals_out = r.literals; cu.phase_out = r.phase;
        last_c = cyc;
    endtask

    task automatic wait_for(input string tag, input logic want_done);
        logic ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (want_done ? done : cu.valid_P) ok = 1;
            else @(negedge clk);
        end
        at = cyc;
        chk(tag, ok, 1);
    endtask

    task automatic ret3(input logic with_flag, input row_t a, b, c);
        int lc;
        cu_drive(with_flag, 0, 0, 1, a);
        cu_drive(0, 0, 0, 1, b);
        cu_drive(0, 0, 0, 1, c);
        lc = last_c;
        model[0] = a; model[1] = b; model[2] = c;
        cu_drive(0, 0, 0, 0, '0);
        wait_for("done_seen", 1);
        chk("done_time", at, lc + 1);
    endtask

    task automatic chk_tab(input string tag);
        for (int k = 0; k < 3; k++) begin
            load_idx = 2'(k);
            #1;
            chk({tag, "_rd_lit"}, rd_literals, model[k].literals);
            chk({tag, "_rd_ph"}, rd_phase, model[k].phase);
        end
    endtask

    task automatic wrap(input string tag, input int ep, input int ed, input logic ee);
        repeat (2) @(negedge clk);
        chk({tag, "_npulse"}, n_p - base_p, ep);
        chk({tag, "_ndone"}, n_done - base_d, ed);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sb_left"}, sb.size(), 0);
        base_p = n_p;
        base_d = n_done;
    endtask

    initial begin
        cu.valid_flag_anticommute = 0; cu.flag_anticommute = 0; cu.valid_out_canonical = 0;
        cu.valid_out = 0; cu.literals_out = 0; cu.phase_out = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_vin", cu.valid_in, 0);
        chk("rst_vp", cu.valid_P, 0);
        chk("rst_bus", {cu.literals_in, cu.phase_in}, 0);
        chk("rst_rd", {rd_literals, rd_phase}, 0);
        @(negedge clk);
        rst = 1;

        // deterministic projection
        load(0, mk(LIT_Z, LIT_I, LIT_I, 8'h00));
        load(1, mk(LIT_I, LIT_Z, LIT_I, 8'h00));
        load(2, mk(LIT_I, LIT_I, LIT_Z, 8'h00));
        chk_tab("load");
        base_p = n_p; base_d = n_done;
        kick(0, 0, '0);
        chk("send_busy", busy, 1);
        wait_for("p_seen", 0);
        chk("p_time", at, t0 + 4);
        cu_drive(1, 0, 0, 0, '0);
        ret3(0, mk(LIT_X, LIT_I, LIT_I, 8'h5a), mk(LIT_I, LIT_Y, LIT_I, 8'h81),
             mk(LIT_I, LIT_I, LIT_X, 8'hff));
        wrap("det", 1, 1, 0);
        chk_tab("det");

        // randomized round then deterministic result
        kick(0, 0, '0);
        wait_for("p_seen", 0);
        cu_drive(1, 1, 0, 0, '0);
        repeat (3) cu_drive(0, 0, 1, 0, '0);
        cu_drive(0, 0, 0, 0, '0);
        wait_for("rep_seen", 0);
        chk("rep_time", at, last_c);
        cu_drive(1, 0, 0, 0, '0);
        ret3(0, mk(LIT_Y, LIT_Z, LIT_X, 8'h3c), mk(LIT_Z, LIT_Z, LIT_I, 8'h01),
             mk(LIT_X, LIT_X, LIT_Y, 8'h80));
        wrap("rand", 2, 1, 0);
        chk_tab("rand");

        // second randomized flag is a protocol error
        kick(0, 0, '0);
        wait_for("p_seen", 0);
        cu_drive(1, 1, 0, 0, '0);
        repeat (3) cu_drive(0, 0, 1, 0, '0);
        cu_drive(0, 0, 0, 0, '0);
        wait_for("rep_seen", 0);
        cu_drive(1, 1, 0, 0, '0);
        cu_drive(0, 0, 0, 0, '0);
        wrap("dbl", 2, 0, 1);
        chk_tab("dbl");

        // start clears err; start/load while busy are ignored; row rides with the flag
        kick(0, 0, '0);
        chk("err_clr", err, 0);
        start = 1; load_valid = 1; load_idx = 1; load_literals = 6'h3f; load_phase = 8'hee;
        @(negedge clk);
        start = 0; load_valid = 0;
        wait_for("p_seen", 0);
        chk("busy_p_time", at, t0 + 4);
        ret3(1, mk(LIT_I, LIT_X, LIT_Z, 8'h42), mk(LIT_Y, LIT_I, LIT_I, 8'h24),
             mk(LIT_Z, LIT_Y, LIT_X, 8'h99));
        wrap("busy", 1, 1, 0);
        chk_tab("busy");

        // asynchronous reset during COLLECT
        kick(0, 0, '0);
        wait_for("p_seen", 0);
        cu_drive(1, 0, 0, 1, mk(LIT_Y, LIT_Y, LIT_Y, 8'h11));
        cu_drive(0, 0, 0, 0, '0);
        chk("collect_busy", busy, 1);
        #2 rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_vin", cu.valid_in, 0);
        chk("arst_vp", cu.valid_P, 0);
        chk("arst_bus", {cu.literals_in, cu.phase_in}, 0);
        for (int k = 0; k < 3; k++) model[k] = '0;
        chk_tab("arst");
        @(negedge clk);
        rst = 1;
        base_p = n_p; base_d = n_done;
        kick(1, 2, mk(LIT_Z, LIT_X, LIT_Y, 8'hc3));
        wait_for("p_seen", 0);
        chk("post_p_time", at, t0 + 4);
        cu_drive(1, 0, 0, 0, '0);
        ret3(0, mk(LIT_X, LIT_Y, LIT_Z, 8'h0f), mk(LIT_Z, LIT_I, LIT_Y, 8'hf0),
             mk(LIT_I, LIT_X, LIT_X, 8'h66));
        wrap("post", 1, 1, 0);
        chk_tab("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cofactor_row_streamer.md
Name: cofactor_row_streamer

Overview:
- Host-side transmitter/receiver for the cofactor control unit.
- Holds a stabilizer tableau of num_qubit rows; each row is num_qubit 2-bit literals plus a 2**num_qubit-bit phase vector.
- On start: streams the rows into the control unit's external input, pulses valid_P, handles an optional randomized (canonical) round, and writes the returned rows back into the tableau in place. Successive projections can therefore be chained.

Parameters:
- num_qubit, 3, qubit count = rows per tableau = literals per row

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  write one tableau row (accepted only in IDLE)
- load_idx  in  $clog2(num_qubit)  row index for load and read
- load_literals  in  2 x num_qubit  row literals
- load_phase  in  2**num_qubit  row phase vector
- start  in  1  begin one projection (accepted only in IDLE)
- rd_literals  out  2 x num_qubit  combinational read of row load_idx
- rd_phase  out  2**num_qubit  combinational read of row load_idx
- valid_in  out  1  row strobe to control unit
- literals_in  out  2 x num_qubit  streamed row literals
- phase_in  out  2**num_qubit  streamed row phase
- valid_P  out  1  one-cycle projection strobe
- valid_flag_anticommute  in  1  outcome-type strobe from cofactor
- flag_anticommute  in  1  1 = randomized outcome
- valid_out_canonical  in  1  canonical row strobe (monitor only)
- valid_out  in  1  result row strobe from control unit
- literals_out  in  2 x num_qubit  result literals
- phase_out  in  2**num_qubit  result phase
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky protocol error; cleared by start or reset

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; row_cnt=0; rand_seen=0.
  - All outputs 0. Tableau contents are cleared to 0.
- All control-unit-facing outputs are registered.
- IDLE:
  - load_valid writes row load_idx.
  - start → SEND at the next edge, row_cnt=0, err cleared.
  - start together with load_valid: the load is applied first; the streamed data includes it.
- SEND:
  - Each cycle: valid_in=1 with row row_cnt; row_cnt increments.
  - After row num_qubit-1 → PULSE_P.
  - With start at edge t, rows appear in cycles t+1..t+num_qubit.
- PULSE_P:
  - valid_P=1 for exactly one cycle (cycle t+num_qubit+1), then → WAIT_FLAG.
- WAIT_FLAG:
  - valid_out rows may arrive before or together with the flag strobe: each is written to tableau[row_cnt] and row_cnt increments. row_cnt is reset to 0 on leaving PULSE_P.
  - valid_flag_anticommute with flag=0: deterministic → COLLECT.
  - valid_flag_anticommute with flag=1 and rand_seen=0: set rand_seen → WAIT_CANON, canonical counter=0.
  - valid_flag_anticommute with flag=1 and rand_seen=1: err=1 → IDLE with no done pulse.
- WAIT_CANON:
  - Count valid_out_canonical strobes.
  - At num_qubit → RE_P, which drives valid_P=1 for one cycle → WAIT_FLAG. Result writeback restarts at row 0.
- COLLECT:
  - Each valid_out writes tableau[row_cnt] and row_cnt increments.
  - At num_qubit → DONE.
- DONE: done=1 for one cycle → IDLE.
- Ignored inputs:
  - valid_out outside WAIT_FLAG/COLLECT.
  - start or load_valid while busy.
  - Extra valid_out after num_qubit rows.
- Reset mid-operation: immediate abort; the tableau is cleared.
- Counter widths: $clog2(num_qubit)+1 bits, so the compare against num_qubit never wraps.

Decomposition:
- Shared package cofactor_pkg:
  - literal encoding constants (I=0, X=1, Z=2, Y=3)
  - row typedef (literals array + phase vector)
  - streamer state enum (IDLE, SEND, PULSE_P, WAIT_FLAG, WAIT_CANON, RE_P, COLLECT, DONE)
- One sub-module, stabilizer_row_buffer: num_qubit-entry register file with one write port (muxed between load and capture) and two combinational read ports (host read, stream read).

Test Plan:
- Load rows {ZII,IZI,IIZ} with phases 0, start, drive a deterministic flag, return 3 rows → valid_in high in cycles t+1..t+3 carrying rows 0..2 in order; valid_P in cycle t+4; done 1 cycle after the 3rd valid_out; rd_* shows the returned rows.
- Randomized: flag=1, 3 valid_out_canonical strobes, then flag=0 and 3 valid_out → exactly two valid_P pulses, one done, err=0.
- Two randomized flags in one projection → err=1, no done, back in IDLE; the next start clears err.
- start and load_valid while busy (mid-SEND) → streamed data and state unchanged; no restart.
- valid_out arriving in the same cycle as the deterministic flag strobe → captured as row 0; the remaining 2 rows complete with done.
- rst=0 asserted during COLLECT → all outputs 0 asynchronously; tableau reads 0; a new load+start runs cleanly.
